op_fetch: RTL and testbench

//  Opcode fetch sequencer upstream of the 256x8 single-port opcode RAM (opram).

---
 rtl/op_fetch_pkg.sv | 31 +++
 rtl/op_fetch_if.sv | 37 +++
 rtl/op_fetch_fifo.sv | 86 ++++++++
 rtl/op_fetch.sv | 138 +++++++++++++
 tb/tb_op_fetch.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/op_fetch_pkg.sv
// ----------------------------------------------------------------------------
// op_fetch_pkg
//  Shared definitions for the opcode fetch sequencer: FSM state encoding,
//  default halt opcode and end address, output FIFO depth, and the credit
//  helper that limits outstanding reads to the FIFO capacity.
// ----------------------------------------------------------------------------
package op_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [7:0] HALT_OP_DEF  = 8'h00;
   localparam logic [7:0] END_ADDR_DEF = 8'hFF;

   // Output FIFO depth; also the cap on FIFO occupancy plus reads in flight.
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   // A new read may be issued when the slot it will land in is guaranteed:
   // current occupancy plus the read in flight, less the byte leaving this
   // cycle, must leave room. Counting the pop keeps 1 byte/cycle sustained.
   function automatic logic has_credit(input logic [CNT_W-1:0] count,
                                       input logic             inflight,
                                       input logic             pop);
      return (int'(count) + int'(inflight) - int'(pop)) < FIFO_DEPTH;
   endfunction

endpackage

// File: rtl/op_fetch_if.sv
// ----------------------------------------------------------------------------
// op_fetch_if
//  Bundles the opram read port and the downstream opcode stream.
//  master : the fetch sequencer (drives RAM address/enables and op_* stream)
//  slave  : the RAM + executor side (drives ram_dout and op_ready)
//  RAM port : ram_ad, ram_ce, ram_oce, ram_wre, ram_dout
//  Stream   : op_data, op_valid, op_ready, op_addr, op_last
// ----------------------------------------------------------------------------
interface op_fetch_if #(parameter int AW = 8) ();

   logic [AW-1:0] ram_ad;
   logic          ram_ce;
   logic          ram_oce;
   logic          ram_wre;
   logic [7:0]    ram_dout;

   logic [7:0]    op_data;
   logic          op_valid;
   logic          op_ready;
   logic [AW-1:0] op_addr;
   logic          op_last;

   modport master (
      output ram_ad, ram_ce, ram_oce, ram_wre,
      input  ram_dout,
      output op_data, op_valid, op_addr, op_last,
      input  op_ready
   );

   modport slave (
      input  ram_ad, ram_ce, ram_oce, ram_wre,
      output ram_dout,
      input  op_data, op_valid, op_addr, op_last,
      output op_ready
   );

endinterface

// File: rtl/op_fetch_fifo.sv
// ----------------------------------------------------------------------------
// op_fetch_fifo
//  Small output FIFO holding {last, addr, data} entries for the opcode stream.
//  Ports: clk, reset (async, active-high), flush (drop all entries),
//         push/push_data, pop, head (oldest entry), empty, count.
//  Push is accepted when not full or when a pop frees a slot the same cycle;
//  flush overrides push and pop. Depth must be a power of two (pointer wrap).
// ----------------------------------------------------------------------------
module op_fetch_fifo
   import op_fetch_pkg::*;
#(
   parameter int W = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [W-1:0]     mem_q [FIFO_DEPTH];
   logic [W-1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      full    = (cnt_q == CNT_W'(FIFO_DEPTH));
      empty   = (cnt_q == '0);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_d = rd_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is updated with nonblocking (<=) so every flop samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: storage is reset as well (only two entries) so op_data and
         // op_addr read zero out of reset instead of X.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/op_fetch.sv
// ----------------------------------------------------------------------------
// op_fetch
//  Opcode fetch sequencer in front of the 256x8 single-port opcode RAM.
//  Issues reads (1-cycle RAM latency), buffers bytes in a 2-entry FIFO and
//  streams them downstream over valid/ready. A run starts at address 0 and
//  ends at the halt opcode or END_ADDR (byte tagged op_last); a jump request
//  in RUN flushes buffered/in-flight bytes and redirects the program counter.
//  Ports: clk, reset (async, active-high), start, jmp_valid, jmp_addr, busy,
//         bus (op_fetch_if.master: RAM read port + opcode stream).
//  Build option: OPFETCH_LOOP_EN -- on halt/END_ADDR stay in RUN and restart
//  fetching at address 0 (continuous loop); busy stays high until reset.
// ----------------------------------------------------------------------------
module op_fetch
   import op_fetch_pkg::*;
#(
   parameter int            AW       = 8,
   parameter logic [7:0]    HALT_OP  = HALT_OP_DEF,
   parameter logic [AW-1:0] END_ADDR = AW'(END_ADDR_DEF)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          jmp_valid,
   input  logic [AW-1:0] jmp_addr,
   output logic          busy,
   op_fetch_if.master    bus
);

   typedef struct packed {
      logic          last;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } entry_t;

   state_e           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;   // address of the read in flight
   logic             inflight_q, inflight_d;

   logic             pop, capture, term, jmp_take, issue;
   entry_t           push_e, head_e;
   logic [$bits(entry_t)-1:0] fifo_head;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   op_fetch_fifo #(.W($bits(entry_t))) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (jmp_take),
      .push      (capture),
      .push_data (push_e),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head_e = entry_t'(fifo_head);

   // Cycle decode shared by next-state and output logic.
   always_comb begin
      pop      = !fifo_empty && bus.op_ready;
      jmp_take = (state_q == ST_RUN) && jmp_valid;
      // Returning data is only kept in RUN; a jump in the same cycle wins
      // and discards it (including a halt byte).
      capture  = (state_q == ST_RUN) && inflight_q && !jmp_take;
      term     = capture && ((bus.ram_dout == HALT_OP) || (rd_addr_q == END_ADDR));
      issue    = (state_q == ST_RUN) && !jmp_take && !term
                 && has_credit(fifo_count, inflight_q, pop);
      push_e   = '{last: term, addr: rd_addr_q, data: bus.ram_dout};
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rd_addr_q  <= rd_addr_d;
         inflight_q <= inflight_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rd_addr_d  = rd_addr_q;
      inflight_d = issue;
      if (issue) begin
         pc_d      = pc_q + AW'(1);
         rd_addr_d = pc_q;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (jmp_take) begin
               pc_d = jmp_addr;
            end else if (term) begin
`ifdef OPFETCH_LOOP_EN
               pc_d = '0;
`else
               state_d = ST_DRAIN;
`endif
            end
         end
         ST_DRAIN: begin
            if (pop && head_e.last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.ram_ad   = pc_q;
      bus.ram_ce   = issue;
      bus.ram_oce  = 1'b1;
      bus.ram_wre  = 1'b0;
      bus.op_valid = !fifo_empty;
      bus.op_data  = head_e.data;
      bus.op_addr  = head_e.addr;
      bus.op_last  = head_e.last;
      busy         = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_op_fetch.sv
// ----------------------------------------------------------------------------
// tb_op_fetch
//  Scoreboard bench for op_fetch: stimulus pushes expected {last,addr,data}
//  entries into a queue; a negedge monitor pops and compares on every
//  accepted byte, and also tracks outstanding reads and stall stability.
// ----------------------------------------------------------------------------
module tb_op_fetch;

   typedef struct packed {
      logic       last;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       jmp_valid;
   logic [7:0] jmp_addr;
   logic       busy;

   op_fetch_if #(.AW(8)) bus ();

   op_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .jmp_valid (jmp_valid),
      .jmp_addr  (jmp_addr),
      .busy      (busy),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Opcode RAM model: registered read, data valid the cycle after ce.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (bus.ram_ce) bus.ram_dout <= mem[bus.ram_ad];
   end

   logic [7:0] prog_a [7] = '{8'h46, 8'h20, 8'h41, 8'h21, 8'h42, 8'h22, 8'h00};

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit   stab_en = 0;
   bit   os_en   = 0;
   int   os_cnt, os_max;
   int   stall_seen = 0;
   int   stall_bad  = 0;
   int   acc_cnt    = 0;
   bit   prev_hold  = 0;
   exp_t prev;

   always @(negedge clk) begin
      exp_t cur, e;
      cur = '{last: bus.op_last, addr: bus.op_addr, data: bus.op_data};
      if (reset) begin
         prev_hold = 0;
      end else begin
         if (stab_en && prev_hold) begin
            stall_seen++;
            if (!bus.op_valid || cur != prev) stall_bad++;
         end
         if (bus.op_valid && bus.op_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_byte: got addr %0h data %0h, expected none", cur.addr, cur.data);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("byte_%0d{last,addr,data}", acc_cnt), 32'(cur), 32'(e));
            end
         end
         if (os_en) begin
            os_cnt += int'(bus.ram_ce) - int'(bus.op_valid && bus.op_ready);
            if (os_cnt > os_max) os_max = os_cnt;
         end
         prev_hold = bus.op_valid && !bus.op_ready;
         prev      = cur;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h11;
      for (int i = 0; i < 7; i++) mem[i] = prog_a[i];
      for (int i = 8'hF0; i < 256; i++) mem[i] = 8'hB0 + 8'(i - 8'hF0);
   endtask

   task automatic push_exp(input logic [7:0] data, input logic [7:0] addr, input logic last);
      exp_q.push_back('{last: last, addr: addr, data: data});
   endtask

   task automatic push_prog_a(input int first);
      for (int i = first; i < 7; i++) push_exp(prog_a[i], 8'(i), i == 6);
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_busy"}, 32'(busy), 0);
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_ce"},   32'(bus.ram_ce),   0);
      check({tag, "_ram_ad"},   32'(bus.ram_ad),   0);
      check({tag, "_ram_oce"},  32'(bus.ram_oce),  1);
      check({tag, "_ram_wre"},  32'(bus.ram_wre),  0);
      check({tag, "_op_valid"}, 32'(bus.op_valid), 0);
      check({tag, "_op_data"},  32'(bus.op_data),  0);
      check({tag, "_op_addr"},  32'(bus.op_addr),  0);
      check({tag, "_op_last"},  32'(bus.op_last),  0);
      check({tag, "_busy"},     32'(busy),         0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, n, v;
      reset        = 1'b1;
      start        = 1'b0;
      jmp_valid    = 1'b0;
      jmp_addr     = 8'h00;
      bus.op_ready = 1'b0;
      load_mem();
      tick(2);
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

`ifdef OPFETCH_LOOP_EN
      // Loop: halt at 6 is tagged last, then fetching resumes at 0.
      push_prog_a(0);
      push_exp(8'h46, 8'h00, 1'b0);
      push_exp(8'h20, 8'h01, 1'b0);
      push_exp(8'h41, 8'h02, 1'b0);
      base = acc_cnt;
      bus.op_ready = 1'b1;
      pulse_start();
      n = 0;
      while (acc_cnt - base < 10 && n < 40) begin
         tick();
         n++;
      end
      bus.op_ready = 1'b0;
      check("loop_accepted", acc_cnt - base, 10);
      check("loop_busy", 32'(busy), 1);
      check("loop_pending", exp_q.size(), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
`else
      // 1) Full run, op_ready held high: latency and sustained rate.
      push_prog_a(0);
      bus.op_ready = 1'b1;
      os_en  = 1;
      os_cnt = 0;
      os_max = 0;
      pulse_start();                       // now in cycle T+1
      check("lat_ce_t1", 32'(bus.ram_ce), 1);
      check("lat_ad_t1", 32'(bus.ram_ad), 0);
      tick();                              // T+2
      check("lat_valid_t2", 32'(bus.op_valid), 0);
      check("lat_ad_t2", 32'(bus.ram_ad), 1);
      tick();                              // T+3
      check("lat_valid_t3", 32'(bus.op_valid), 1);
      check("lat_addr_t3", 32'(bus.op_addr), 0);
      v = 0;
      repeat (6) begin
         tick();
         v += int'(bus.op_valid);
      end
      check("sustained_valid", v, 6);
      tick();                              // cycle after last byte taken
      check("run_busy_after_last", 32'(busy), 0);
      check("run_valid_after_last", 32'(bus.op_valid), 0);
      wait_done("run", 20);
      check("run_outstanding_le2", 32'(os_max <= 2), 1);
      os_en = 0;

      // 2) Same image with op_ready toggling every cycle.
      push_prog_a(0);
      bus.op_ready = 1'b1;
      os_cnt     = 0;
      os_max     = 0;
      stall_seen = 0;
      stall_bad  = 0;
      os_en      = 1;
      stab_en    = 1;
      pulse_start();
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 60) begin
         tick();
         bus.op_ready = ~bus.op_ready;
         n++;
      end
      stab_en = 0;
      os_en   = 0;
      check("toggle_busy", 32'(busy), 0);
      check("toggle_pending", exp_q.size(), 0);
      check("toggle_stall_seen", 32'(stall_seen > 0), 1);
      check("toggle_stall_unstable", stall_bad, 0);
      check("toggle_outstanding_le2", 32'(os_max <= 2), 1);

      // 3) Jump to 4 while the byte from addr 1 is pending.
      push_exp(8'h46, 8'h00, 1'b0);
      push_prog_a(4);
      base = acc_cnt;
      bus.op_ready = 1'b0;
      pulse_start();
      n = 0;
      while (!(bus.op_valid && bus.op_addr == 8'h00) && n < 10) begin
         tick();
         n++;
      end
      check("jmp_first_valid", 32'(bus.op_valid), 1);
      tick(3);
      bus.op_ready = 1'b1;                 // take exactly the addr-0 byte
      tick();
      bus.op_ready = 1'b0;
      check("jmp_pending_addr", 32'(bus.op_addr), 1);
      jmp_valid = 1'b1;
      jmp_addr  = 8'h04;
      tick();
      jmp_valid = 1'b0;
      bus.op_ready = 1'b1;
      wait_done("jmp", 30);
      check("jmp_accepted", acc_cnt - base, 4);

      // 4) Jump to 0xFE: run ends at END_ADDR.
      push_exp(8'hBE, 8'hFE, 1'b0);
      push_exp(8'hBF, 8'hFF, 1'b1);
      base = acc_cnt;
      bus.op_ready = 1'b0;
      pulse_start();
      tick(5);
      jmp_valid = 1'b1;
      jmp_addr  = 8'hFE;
      tick();
      jmp_valid = 1'b0;
      bus.op_ready = 1'b1;
      wait_done("end_addr", 30);
      check("end_addr_accepted", acc_cnt - base, 2);

      // 5) Reset mid-run with the FIFO full, then a fresh run from 0.
      bus.op_ready = 1'b0;
      pulse_start();
      tick(5);
      check("midrst_full_valid", 32'(bus.op_valid), 1);
      reset = 1'b1;
      #2;
      check_reset_outputs("midrst");
      tick();
      reset = 1'b0;
      push_prog_a(0);
      bus.op_ready = 1'b1;
      pulse_start();
      check("midrst_restart_ce", 32'(bus.ram_ce), 1);
      check("midrst_restart_ad", 32'(bus.ram_ad), 0);
      wait_done("midrst_run", 30);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
